// File: rtl/l2_cache_tag_lookup_pkg.sv
// Shared types for the L2 tag lookup stage: default geometry, index types,
// lookup result struct and the invalidate-sweep state encoding.
package l2_cache_tag_lookup_pkg;

  localparam int L2_NUM_SETS      = 256;
  localparam int L2_NUM_WAYS      = 8;
  localparam int L2_TAG_WIDTH     = 18;
  localparam int L2_SET_IDX_WIDTH = $clog2(L2_NUM_SETS);
  localparam int L2_WAY_IDX_WIDTH = $clog2(L2_NUM_WAYS);

  typedef logic [L2_WAY_IDX_WIDTH-1:0] l2_way_idx_t;
  typedef logic [L2_SET_IDX_WIDTH-1:0] l2_set_idx_t;

  typedef struct packed {
    logic [L2_NUM_WAYS-1:0]                   valid;
    logic [L2_NUM_WAYS-1:0][L2_TAG_WIDTH-1:0] tags;
    logic [L2_NUM_WAYS-1:0]                   dirty;
  } tag_lookup_result_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } l2_sweep_state_e;

endpackage

// File: rtl/l2_cache_tag_lookup_chk.sv
// Simulation checker for the tag lookup stage: at most one valid way may match.
module l2_cache_tag_lookup_chk #(
  parameter int NUM_WAYS = 8
) (
  input logic                clk,
  input logic                reset,
  input logic [NUM_WAYS-1:0] match
);

  a_single_match: assert property (@(posedge clk) disable iff (reset) $onehot0(match))
    else $error("multiple valid ways match the lookup tag: %b", match);

endmodule

// File: rtl/l2_cache_tag_lookup_way_array.sv
// One way of the L2 tag store: tag and dirty 1r1w arrays plus a reset flop
// valid array, all read with new-data-on-collision semantics.
module l2_tag_way_array #(
  parameter  int NUM_SETS      = 256,
  parameter  int TAG_WIDTH     = 18,
  localparam int SET_IDX_WIDTH = $clog2(NUM_SETS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_en,
  input  logic [SET_IDX_WIDTH-1:0] rd_set,
  input  logic                     tag_we,
  input  logic [SET_IDX_WIDTH-1:0] tag_set,
  input  logic                     valid_in,
  input  logic [TAG_WIDTH-1:0]     tag_in,
  input  logic                     dirty_we,
  input  logic [SET_IDX_WIDTH-1:0] dirty_set,
  input  logic                     dirty_in,
  input  logic                     clr_en,
  input  logic [SET_IDX_WIDTH-1:0] clr_set,
  output logic                     rd_valid,
  output logic [TAG_WIDTH-1:0]     rd_tag,
  output logic                     rd_dirty
);

  logic [TAG_WIDTH-1:0] tag_mem_r [NUM_SETS];
  logic [NUM_SETS-1:0]  dirty_mem_r;
  logic [NUM_SETS-1:0]  valid_r;

  // Tag array write
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem_r[tag_set] <= tag_in;
    end
  end

  // Dirty array write; the sweep clear is last so it wins on a same-set clash
  always_ff @(posedge clk) begin
    if (dirty_we) begin
      dirty_mem_r[dirty_set] <= dirty_in;
    end
    if (clr_en) begin
      dirty_mem_r[clr_set] <= 1'b0;
    end
  end

  // Valid flops with async reset; sweep clear again has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {NUM_SETS{1'b0}};
    end else begin
      if (tag_we) begin
        valid_r[tag_set] <= valid_in;
      end
      if (clr_en) begin
        valid_r[clr_set] <= 1'b0;
      end
    end
  end

  // Gated read with same-cycle write forwarding
  always_comb begin
    rd_valid = 1'b0;
    rd_tag   = {TAG_WIDTH{1'b0}};
    rd_dirty = 1'b0;
    if (rd_en) begin
      rd_tag   = (tag_we && (tag_set == rd_set)) ? tag_in : tag_mem_r[rd_set];
      rd_valid = (clr_en && (clr_set == rd_set)) ? 1'b0 :
                 (tag_we && (tag_set == rd_set)) ? valid_in : valid_r[rd_set];
      rd_dirty = (clr_en && (clr_set == rd_set)) ? 1'b0 :
                 (dirty_we && (dirty_set == rd_set)) ? dirty_in : dirty_mem_r[rd_set];
    end else begin
      rd_valid = 1'b0;
    end
  end

endmodule

// File: rtl/l2_cache_tag_lookup.sv
// L2 tag lookup stage: one-cycle tag/valid/dirty read for all ways, in-stage
// hit compare, stall hold with write patching, and invalidate-all sweep.
module l2_cache_tag_lookup
  import l2_cache_tag_lookup_pkg::*;
#(
  parameter  int NUM_SETS      = L2_NUM_SETS,
  parameter  int NUM_WAYS      = L2_NUM_WAYS,
  parameter  int TAG_WIDTH     = L2_TAG_WIDTH,
  localparam int SET_IDX_WIDTH = $clog2(NUM_SETS),
  localparam int WAY_IDX_WIDTH = $clog2(NUM_WAYS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [SET_IDX_WIDTH-1:0]      req_set,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  input  logic                          stall,
  input  logic [NUM_WAYS-1:0]           update_tag_en,
  input  logic [SET_IDX_WIDTH-1:0]      update_set,
  input  logic                          update_valid,
  input  logic [TAG_WIDTH-1:0]          update_tag,
  input  logic [NUM_WAYS-1:0]           update_dirty_en,
  input  logic [SET_IDX_WIDTH-1:0]      update_dirty_set,
  input  logic                          update_dirty_value,
  input  logic                          inval_all_start,
  output logic                          inval_busy,
  output logic                          out_valid,
  output logic [SET_IDX_WIDTH-1:0]      out_set,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [NUM_WAYS-1:0]           out_way_valid,
  output logic [NUM_WAYS-1:0]           out_way_dirty,
  output logic [NUM_WAYS*TAG_WIDTH-1:0] out_way_tags,
  output logic                          out_hit,
  output logic [WAY_IDX_WIDTH-1:0]      out_hit_way
);

  l2_sweep_state_e                   state_r, state_nxt_s;
  logic [SET_IDX_WIDTH-1:0]          sweep_cnt_r, sweep_cnt_nxt_s;
  logic                              sweep_clr_s, sweep_enter_s, accept_s, held_clr_s;
  logic [NUM_WAYS-1:0]               rd_valid_s, rd_dirty_s;
  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] rd_tag_s;
  logic                              out_valid_r;
  logic [SET_IDX_WIDTH-1:0]          out_set_r;
  logic [TAG_WIDTH-1:0]              out_tag_r;
  logic [NUM_WAYS-1:0]               way_valid_r, way_dirty_r;
  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] way_tag_r;
  logic [NUM_WAYS-1:0]               held_valid_s, held_dirty_s;
  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] held_tag_s;
  logic [NUM_WAYS-1:0]               match_s;

  function automatic logic [WAY_IDX_WIDTH-1:0] lowest_way(input logic [NUM_WAYS-1:0] m);
    lowest_way = {WAY_IDX_WIDTH{1'b0}};
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      lowest_way = m[w] ? WAY_IDX_WIDTH'(w) : lowest_way;
    end
  endfunction

  assign req_ready     = !stall && (state_r == ST_IDLE);
  assign accept_s      = req_valid && req_ready;
  assign sweep_enter_s = (state_r == ST_IDLE) && inval_all_start;
  assign inval_busy    = (state_r == ST_SWEEP);

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    l2_tag_way_array #(
      .NUM_SETS  (NUM_SETS),
      .TAG_WIDTH (TAG_WIDTH)
    ) u_way (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (accept_s),
      .rd_set    (req_set),
      .tag_we    (update_tag_en[w]),
      .tag_set   (update_set),
      .valid_in  (update_valid),
      .tag_in    (update_tag),
      .dirty_we  (update_dirty_en[w]),
      .dirty_set (update_dirty_set),
      .dirty_in  (update_dirty_value),
      .clr_en    (sweep_clr_s),
      .clr_set   (sweep_cnt_r),
      .rd_valid  (rd_valid_s[w]),
      .rd_tag    (rd_tag_s[w]),
      .rd_dirty  (rd_dirty_s[w])
    );
  end

  // Sweep state and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sweep_cnt_r <= {SET_IDX_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      sweep_cnt_r <= sweep_cnt_nxt_s;
    end
  end

  // Sweep next state; a start pulse during a sweep is ignored
  always_comb begin
    state_nxt_s     = state_r;
    sweep_cnt_nxt_s = sweep_cnt_r;
    sweep_clr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (inval_all_start) begin
          state_nxt_s     = ST_SWEEP;
          sweep_cnt_nxt_s = {SET_IDX_WIDTH{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        sweep_clr_s     = 1'b1;
        sweep_cnt_nxt_s = sweep_cnt_r + {{(SET_IDX_WIDTH-1){1'b0}}, 1'b1};
        if (sweep_cnt_r == SET_IDX_WIDTH'(NUM_SETS - 1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SWEEP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign held_clr_s = sweep_clr_s && (sweep_cnt_r == out_set_r);

  // Held result patched by writes aimed at the held set
  always_comb begin
    held_valid_s = way_valid_r;
    held_tag_s   = way_tag_r;
    held_dirty_s = way_dirty_r;
    for (int w = 0; w < NUM_WAYS; w++) begin
      held_tag_s[w]   = (update_tag_en[w] && (update_set == out_set_r)) ? update_tag : way_tag_r[w];
      held_valid_s[w] = held_clr_s ? 1'b0 :
                        (update_tag_en[w] && (update_set == out_set_r)) ? update_valid : way_valid_r[w];
      held_dirty_s[w] = held_clr_s ? 1'b0 :
                        (update_dirty_en[w] && (update_dirty_set == out_set_r)) ? update_dirty_value
                                                                                : way_dirty_r[w];
    end
  end

  // Output stage: load on accept, hold and patch otherwise, drop valids on sweep entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_set_r   <= {SET_IDX_WIDTH{1'b0}};
      out_tag_r   <= {TAG_WIDTH{1'b0}};
      way_valid_r <= {NUM_WAYS{1'b0}};
      way_dirty_r <= {NUM_WAYS{1'b0}};
      way_tag_r   <= {(NUM_WAYS*TAG_WIDTH){1'b0}};
    end else if (sweep_enter_s) begin
      out_valid_r <= 1'b0;
      way_valid_r <= {NUM_WAYS{1'b0}};
      way_dirty_r <= held_dirty_s;
      way_tag_r   <= held_tag_s;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_set_r   <= req_set;
      out_tag_r   <= req_tag;
      way_valid_r <= rd_valid_s;
      way_dirty_r <= rd_dirty_s;
      way_tag_r   <= rd_tag_s;
    end else begin
      out_valid_r <= out_valid_r && stall;
      way_valid_r <= held_valid_s;
      way_dirty_r <= held_dirty_s;
      way_tag_r   <= held_tag_s;
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_match
    assign match_s[w] = way_valid_r[w] && (way_tag_r[w] == out_tag_r);
  end

  assign out_valid     = out_valid_r;
  assign out_set       = out_set_r;
  assign out_tag       = out_tag_r;
  assign out_way_valid = way_valid_r;
  assign out_way_dirty = way_dirty_r & way_valid_r;
  assign out_way_tags  = way_tag_r;
  assign out_hit       = |match_s;
  assign out_hit_way   = lowest_way(match_s);

  l2_cache_tag_lookup_chk #(
    .NUM_WAYS (NUM_WAYS)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .match (match_s)
  );

endmodule

// File: tb/tb_l2_cache_tag_lookup.sv
// Directed self-checking bench for l2_cache_tag_lookup (default geometry).
module tb_l2_cache_tag_lookup;

  localparam int SW = 8;
  localparam int NW = 8;
  localparam int TW = 18;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_set;
  logic [TW-1:0] req_tag;
  logic          stall;
  logic [NW-1:0] update_tag_en;
  logic [SW-1:0] update_set;
  logic          update_valid;
  logic [TW-1:0] update_tag;
  logic [NW-1:0] update_dirty_en;
  logic [SW-1:0] update_dirty_set;
  logic          update_dirty_value;
  logic          inval_all_start;
  logic          inval_busy;
  logic          out_valid;
  logic [SW-1:0] out_set;
  logic [TW-1:0] out_tag;
  logic [NW-1:0] out_way_valid;
  logic [NW-1:0] out_way_dirty;
  logic [NW*TW-1:0] out_way_tags;
  logic          out_hit;
  logic [2:0]    out_hit_way;

  int n_tests = 0;
  int n_fail  = 0;

  l2_cache_tag_lookup dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_set            (req_set),
    .req_tag            (req_tag),
    .stall              (stall),
    .update_tag_en      (update_tag_en),
    .update_set         (update_set),
    .update_valid       (update_valid),
    .update_tag         (update_tag),
    .update_dirty_en    (update_dirty_en),
    .update_dirty_set   (update_dirty_set),
    .update_dirty_value (update_dirty_value),
    .inval_all_start    (inval_all_start),
    .inval_busy         (inval_busy),
    .out_valid          (out_valid),
    .out_set            (out_set),
    .out_tag            (out_tag),
    .out_way_valid      (out_way_valid),
    .out_way_dirty      (out_way_dirty),
    .out_way_tags       (out_way_tags),
    .out_hit            (out_hit),
    .out_hit_way        (out_hit_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [SW-1:0] set, input int way, input logic [TW-1:0] tag, input logic v);
    update_tag_en = 8'b1 << way;
    update_set    = set;
    update_tag    = tag;
    update_valid  = v;
    tick();
    update_tag_en = 8'h00;
  endtask

  task automatic do_dirty(input logic [SW-1:0] set, input int way, input logic d);
    update_dirty_en    = 8'b1 << way;
    update_dirty_set   = set;
    update_dirty_value = d;
    tick();
    update_dirty_en = 8'h00;
  endtask

  task automatic lookup(input logic [SW-1:0] set, input logic [TW-1:0] tag);
    req_valid = 1'b1;
    req_set   = set;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (inval_busy && g < 1000) begin
      tick();
      g++;
    end
    check(name, inval_busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    int bad;
    reset = 1'b1; req_valid = 1'b0; req_set = 8'h00; req_tag = 18'h0; stall = 1'b0;
    update_tag_en = 8'h00; update_set = 8'h00; update_valid = 1'b0; update_tag = 18'h0;
    update_dirty_en = 8'h00; update_dirty_set = 8'h00; update_dirty_value = 1'b0;
    inval_all_start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", inval_busy, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_hit", out_hit, 1'b0);
    check("rst_way_valid", out_way_valid, 8'h00);
    tick();

    // basic hit / miss
    do_write(8'd5, 2, 18'h1ABC, 1'b1);
    lookup(8'd5, 18'h1ABC);
    check("hit_valid", out_valid, 1'b1);
    check("hit_hit", out_hit, 1'b1);
    check("hit_way", out_hit_way, 3'd2);
    check("hit_set", out_set, 8'd5);
    check("hit_way_valid", out_way_valid, 8'h04);
    check("hit_tag2", out_way_tags[2*TW +: TW], 18'h1ABC);
    lookup(8'd5, 18'h1ABD);
    check("miss_valid", out_valid, 1'b1);
    check("miss_hit", out_hit, 1'b0);
    tick();
    check("idle_out_valid", out_valid, 1'b0);

    // same-cycle write/read bypass
    update_tag_en = 8'h01; update_set = 8'd7; update_tag = 18'h33; update_valid = 1'b1;
    req_valid = 1'b1; req_set = 8'd7; req_tag = 18'h33;
    tick();
    update_tag_en = 8'h00; req_valid = 1'b0;
    check("byp_hit", out_hit, 1'b1);
    check("byp_way", out_hit_way, 3'd0);
    check("byp_way_valid", out_way_valid, 8'h01);

    // stall coherence
    do_write(8'd9, 3, 18'h99, 1'b1);
    lookup(8'd9, 18'h99);
    check("stl_pre_hit", out_hit, 1'b1);
    check("stl_pre_way", out_hit_way, 3'd3);
    stall = 1'b1; req_valid = 1'b1; req_set = 8'd5; req_tag = 18'h1ABC;
    update_tag_en = 8'h08; update_set = 8'd9; update_tag = 18'h99; update_valid = 1'b0;
    #1;
    check("stl_ready0", req_ready, 1'b0);
    tick();
    update_tag_en = 8'h00;
    check("stl_way3", out_way_valid[3], 1'b0);
    check("stl_hit", out_hit, 1'b0);
    check("stl_held_valid", out_valid, 1'b1);
    check("stl_held_set", out_set, 8'd9);
    check("stl_ready1", req_ready, 1'b0);
    tick();
    check("stl_ready2", req_ready, 1'b0);
    check("stl_held_set2", out_set, 8'd9);
    stall = 1'b0; req_valid = 1'b0;
    tick();
    check("stl_release", out_valid, 1'b0);

    // tag+dirty in one cycle, then dirty masking by valid
    update_tag_en = 8'h02; update_set = 8'd3; update_tag = 18'h55; update_valid = 1'b1;
    update_dirty_en = 8'h02; update_dirty_set = 8'd3; update_dirty_value = 1'b1;
    tick();
    update_tag_en = 8'h00; update_dirty_en = 8'h00;
    lookup(8'd3, 18'h55);
    check("dty_hit_way", out_hit_way, 3'd1);
    check("dty_dirty", out_way_dirty, 8'h02);
    do_write(8'd3, 1, 18'h55, 1'b0);
    lookup(8'd3, 18'h55);
    check("dty_masked", out_way_dirty, 8'h00);
    check("dty_miss", out_hit, 1'b0);

    // full sweep
    do_write(8'd0, 0, 18'h10, 1'b1);
    do_dirty(8'd0, 0, 1'b1);
    do_write(8'd128, 5, 18'h20, 1'b1);
    do_dirty(8'd128, 5, 1'b1);
    do_write(8'd255, 7, 18'h30, 1'b1);
    lookup(8'd128, 18'h20);
    check("swp_pre_hit", out_hit, 1'b1);
    check("swp_pre_dirty", out_way_dirty, 8'h20);
    inval_all_start = 1'b1;
    tick();
    inval_all_start = 1'b0;
    check("swp_busy", inval_busy, 1'b1);
    check("swp_out_valid", out_valid, 1'b0);
    check("swp_way_valid", out_way_valid, 8'h00);
    req_valid = 1'b1; req_set = 8'd128; req_tag = 18'h20;
    busy_cycles = 0;
    bad = 0;
    while (inval_busy && busy_cycles < 1000) begin
      busy_cycles++;
      if (req_ready || out_valid) bad++;
      inval_all_start = (busy_cycles == 50);
      tick();
    end
    inval_all_start = 1'b0;
    req_valid = 1'b0;
    check("swp_busy_cycles", busy_cycles, 256);
    check("swp_ready_low", bad, 0);
    lookup(8'd0, 18'h10);
    check("swp_s0_hit", out_hit, 1'b0);
    check("swp_s0_dirty", out_way_dirty, 8'h00);
    lookup(8'd128, 18'h20);
    check("swp_s128_hit", out_hit, 1'b0);
    check("swp_s128_valid", out_way_valid, 8'h00);
    lookup(8'd255, 18'h30);
    check("swp_s255_hit", out_hit, 1'b0);

    // collision with sweep counter, and a normal update to a swept set
    inval_all_start = 1'b1;
    tick();
    inval_all_start = 1'b0;
    repeat (40) tick();
    update_tag_en = 8'h10; update_set = 8'd40; update_tag = 18'h44; update_valid = 1'b1;
    update_dirty_en = 8'h10; update_dirty_set = 8'd40; update_dirty_value = 1'b1;
    tick();
    update_tag_en = 8'h00; update_dirty_en = 8'h00;
    repeat (19) tick();
    do_write(8'd10, 6, 18'h66, 1'b1);
    wait_idle("col_done");
    lookup(8'd40, 18'h44);
    check("col_s40_hit", out_hit, 1'b0);
    check("col_s40_valid", out_way_valid, 8'h00);
    lookup(8'd10, 18'h66);
    check("col_s10_hit", out_hit, 1'b1);
    check("col_s10_way", out_hit_way, 3'd6);

    // reset in the middle of a sweep
    inval_all_start = 1'b1;
    tick();
    inval_all_start = 1'b0;
    repeat (100) tick();
    check("rms_busy", inval_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("rms_busy_clr", inval_busy, 1'b0);
    #2;
    reset = 1'b0;
    tick();
    check("rms_ready", req_ready, 1'b1);
    lookup(8'd10, 18'h66);
    check("rms_valid", out_valid, 1'b1);
    check("rms_hit", out_hit, 1'b0);
    check("rms_way_valid", out_way_valid, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
